neosd_blk_buf: RTL
==================

// Module: neosd_blk_buf
// PURPOSE
//  Word-wide data block buffer between the Wishbone DATA register (host side) and the SD DAT state machine (card side).
//  Lets software move a whole block without per-word stalls on the SD clock.
//  Direction selects the producer: TX (host pushes, card pops) or RX (card pushes, host pops).
//  Level/threshold flags feed the IRQ flag register; the block has no bus logic of its own.
// PARAMETERS
//  DEPTH   128  entries of 32 bit; power of two, >=4 (128 = one 512-byte block)
//  THRESH  64   level/space threshold for thresh_o; 1..DEPTH
// PORTS
//  clk_i         in   1          system clock
//  rstn_i        in   1          synchronous reset, active low
//  dir_i         in   1          0 = TX (to card), 1 = RX (from card)
//  flush_i       in   1          discard contents, pointers to 0
//  host_wr_i     in   1          host push strobe (honoured only when dir_i=0)
//  host_dat_i    in   32         host push data
//  host_rd_i     in   1          host pop strobe (honoured only when dir_i=1)
//  host_dat_o    out  32         head entry, host view
//  card_wr_i     in   1          card push strobe (honoured only when dir_i=1)
//  card_dat_i    in   32         card push data
//  card_rd_i     in   1          card pop strobe (honoured only when dir_i=0)
//  card_dat_o    out  32         head entry, card view
//  level_o       out  $clog2(DEPTH)+1  current entry count
//  empty_o       out  1          level_o == 0
//  full_o        out  1          level_o == DEPTH
//  thresh_o      out  1          RX: level>=THRESH; TX: DEPTH-level>=THRESH
//  thresh_irq_o  out  1          one-cycle pulse on rising edge of thresh_o
// BEHAVIOUR
//  - Reset (rstn_i=0 at clk_i edge): pointers/level=0, empty_o=1, full_o=0, thresh_irq_o=0,
//    thresh_o per formula (TX:1, RX:0), *_dat_o=0; storage not cleared.
//  - Show-ahead: *_dat_o = head entry combinationally while !empty_o, 32'h0 when empty.
//    Pop advances head; new head visible the cycle after the pop edge.
//  - Push writes at tail on the clock edge; level_o updates same edge (1-cycle latency to flags).
//  - Producer/consumer selected by dir_i; strobes from the inactive side are ignored.
//  - Push when full: dropped, no state change. Pop when empty: ignored, data undefined-free (0).
//  - Simultaneous push+pop: full -> both accepted, level unchanged;
//    empty -> push accepted, pop ignored; otherwise both accepted.
//  - Priority: reset > flush_i > dir_i change > push/pop.
//  - Any dir_i change (registered edge detect) performs an implicit flush in the following cycle;
//    strobes in that cycle are ignored.
//  - flush_i same-cycle as push: push discarded.
//  - Pointers: $clog2(DEPTH) bits, natural wrap; level from separate counter, saturating never needed.
//  - thresh_irq_o: registered previous thresh_o, pulse = thresh_o & ~prev; suppressed the cycle after flush/reset.
// CONFIGURATION
//  NEOSD_BUF_ERR_EN defined: adds outputs ovf_o / unf_o (1 bit, reset 0), sticky:
//    set on dropped push / ignored pop; cleared by flush_i or implicit flush.
//  Undefined: ports absent, dropped strobes silently ignored; all other behaviour identical.
// STRUCTURE
//  neosd_pkg: neosd_dir_e {NEOSD_DIR_TX=0, NEOSD_DIR_RX=1}, NEOSD_BLK_WORDS=128, NEOSD_WORD_W=32.
//  Sub-module neosd_buf_mem: DEPTH x 32 register array, 1 sync write port, 1 async read port.
//  Top handles pointers, level counter, direction mux, flags, IRQ edge.
// TESTING
//  1 TX fill: dir=0, 128 host pushes 0..127 -> full_o=1, level=128; 129th push dropped (ovf_o=1 if ERR_EN).
//  2 TX drain: 128 card pops -> card_dat_o sequence 0..127, empty_o=1, thresh_irq_o pulse once at level 64.
//  3 RX threshold: dir=1, card pushes 64 words -> thresh_o rises at level 64, thresh_irq_o exactly 1 cycle.
//  4 Simultaneous: full + push+pop -> level stays 128; empty + push+pop -> level 1, head = pushed word.
//  5 Direction flip at level 10 -> next cycle level 0, empty_o=1, strobes that cycle ignored.
//  6 Reset mid-transfer at level 37 with strobes active -> level 0, empty_o=1, outputs 0 next cycle.

Source files
------------

// File: rtl/neosd_pkg.sv
// neosd_pkg: shared types and sizes for the NEOSD data path
package neosd_pkg;

  typedef enum logic {
    NEOSD_DIR_TX = 1'b0,
    NEOSD_DIR_RX = 1'b1
  } neosd_dir_e;

  localparam int NEOSD_BLK_WORDS = 128;
  localparam int NEOSD_WORD_W    = 32;

endpackage

// File: rtl/neosd_buf_mem.sv
// neosd_buf_mem: DEPTH x 32 register array, one synchronous write port, one asynchronous read port
module neosd_buf_mem
  import neosd_pkg::*;
#(
  parameter int DEPTH = NEOSD_BLK_WORDS
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  logic [NEOSD_WORD_W-1:0]    wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output logic [NEOSD_WORD_W-1:0]    rdata_o
);

  logic [NEOSD_WORD_W-1:0] mem [DEPTH];

  // storage is never cleared; only the pointers in the parent define validity
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/neosd_blk_buf.sv
// neosd_blk_buf: show-ahead block buffer between host DATA register and SD DAT engine.
// Define NEOSD_BUF_ERR_EN to add sticky ovf_o/unf_o error flags.
module neosd_blk_buf
  import neosd_pkg::*;
#(
  parameter int DEPTH  = NEOSD_BLK_WORDS,
  parameter int THRESH = 64
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       dir_i,
  input  logic                       flush_i,
  input  logic                       host_wr_i,
  input  logic [NEOSD_WORD_W-1:0]    host_dat_i,
  input  logic                       host_rd_i,
  output logic [NEOSD_WORD_W-1:0]    host_dat_o,
  input  logic                       card_wr_i,
  input  logic [NEOSD_WORD_W-1:0]    card_dat_i,
  input  logic                       card_rd_i,
  output logic [NEOSD_WORD_W-1:0]    card_dat_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       thresh_o,
`ifdef NEOSD_BUF_ERR_EN
  output logic                       ovf_o,
  output logic                       unf_o,
`endif
  output logic                       thresh_irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DP = LW'(DEPTH);
  localparam logic [LW-1:0] TH = LW'(THRESH);

  logic [AW-1:0] wp, rp;
  logic [LW-1:0] level;
  logic dir_q, thr_q, sup_q;
  logic rx, clr, push_req, pop_req, push, pop, empty, full, thr;
  logic [NEOSD_WORD_W-1:0] head;

  // direction mux, accept decisions and threshold; flush or a direction change blocks all strobes
  always_comb begin
    rx       = (neosd_dir_e'(dir_i) == NEOSD_DIR_RX);
    clr      = flush_i | (dir_i ^ dir_q);
    push_req = rx ? card_wr_i : host_wr_i;
    pop_req  = rx ? host_rd_i : card_rd_i;
    empty    = (level == '0);
    full     = (level == DP);
    pop      = pop_req & ~empty & ~clr;
    push     = push_req & (~full | pop) & ~clr;
    thr      = rx ? (level >= TH) : ((DP - level) >= TH);
  end

  // pointers, level counter and the registers behind direction/threshold edge detection
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
      dir_q <= dir_i;
      thr_q <= 1'b0;
      sup_q <= 1'b1;
    end else begin
      dir_q <= dir_i;
      thr_q <= thr;
      sup_q <= clr;
      if (clr) begin
        wp    <= '0;
        rp    <= '0;
        level <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        level <= level + LW'(push) - LW'(pop);
      end
    end
  end

`ifdef NEOSD_BUF_ERR_EN
  // sticky drop/underflow flags, cleared by any flush
  always_ff @(posedge clk_i) begin
    if (!rstn_i || clr) begin
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      if (push_req & ~push) ovf_o <= 1'b1;
      if (pop_req & ~pop) unf_o <= 1'b1;
    end
  end
`endif

  neosd_buf_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_i   (clk_i),
    .we_i    (push),
    .waddr_i (wp),
    .wdata_i (rx ? card_dat_i : host_dat_i),
    .raddr_i (rp),
    .rdata_o (head)
  );

  assign host_dat_o   = empty ? '0 : head;
  assign card_dat_o   = empty ? '0 : head;
  assign level_o      = level;
  assign empty_o      = empty;
  assign full_o       = full;
  assign thresh_o     = thr;
  assign thresh_irq_o = thr & ~thr_q & ~sup_q;

endmodule
